// File: rtl/branch_resolve_bht_pkg.sv
// Shared constants for the branch resolve / BHT block.
//   - 2-bit saturating counter encodings
//   - resolve FSM state type
//   - sequential PC step
package branch_resolve_bht_pkg;

  localparam logic [1:0] SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] WNT = 2'b01;  // weakly not-taken (reset value)
  localparam logic [1:0] WT  = 2'b10;  // weakly taken
  localparam logic [1:0] ST  = 2'b11;  // strongly taken

  typedef enum logic {
    S_NORMAL   = 1'b0,
    S_REDIRECT = 1'b1
  } state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/branch_resolve_bht_bht.sv
// bht_2bit: table of 2-bit saturating direction counters.
// Ports:
//   clk, rst           clock, synchronous active-high reset (all entries -> WNT)
//   rd_idx / rd_cnt    combinational read port (fetch side)
//   wr_en / wr_idx     update strobe and index (execute side)
//   wr_taken           resolved direction: step counter up (1) or down (0)
// A same-cycle read of the entry being written returns the old value.
module bht_2bit
  import branch_resolve_bht_pkg::*;
#(
  parameter int IDX_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [1:0]          rd_cnt,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_taken
);

  localparam int N = 1 << IDX_BITS;

  logic [N-1:0][1:0] tbl;
  logic [1:0]        cur;
  logic [1:0]        nxt;

  assign rd_cnt = tbl[rd_idx];
  assign cur    = tbl[wr_idx];

  always_comb begin
    nxt = cur;
    if (wr_taken) nxt = (cur == ST)  ? ST  : cur + 2'd1;
    else          nxt = (cur == SNT) ? SNT : cur - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) tbl[i] <= WNT;
    end else if (wr_en) begin
      tbl[wr_idx] <= nxt;
    end
  end

endmodule

// File: rtl/branch_resolve_bht.sv
// branch_resolve_bht: resolves BEQ/BNE in EX from the comparator's not-equal
// flag, trains the BHT, and on a misprediction emits a one-cycle registered
// redirect + flush.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_pc / if_pred_taken         fetch-side prediction lookup (combinational)
//   ex_valid, ex_is_branch,
//   ex_is_bne, ex_pc, ex_target,
//   ex_pred_taken, BrRes          EX-stage branch and its comparator result
//   redirect_valid, redirect_pc,
//   flush                         registered redirect request, one cycle wide
//   mispredict_cnt                saturating mispredict statistics
module branch_resolve_bht
  import branch_resolve_bht_pkg::*;
#(
  parameter int IDX_BITS = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_bne,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic             BrRes,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] mispredict_cnt
);

  state_t     state, state_nxt;
  logic       resolve;
  logic       taken;
  logic       mispredict;
  logic [1:0] rd_cnt;

  // only the index bits of the fetch PC select an entry
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[31:IDX_BITS+2], if_pc[1:0]};

  // the REDIRECT slot holds a squashed wrong-path instruction: ignore it
  assign resolve    = ex_valid & ex_is_branch & (state == S_NORMAL);
  assign taken      = ex_is_bne ? BrRes : ~BrRes;
  assign mispredict = taken ^ ex_pred_taken;

  bht_2bit #(.IDX_BITS(IDX_BITS)) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (if_pc[IDX_BITS+1:2]),
    .rd_cnt   (rd_cnt),
    .wr_en    (resolve),
    .wr_idx   (ex_pc[IDX_BITS+1:2]),
    .wr_taken (taken)
  );

  assign if_pred_taken = rd_cnt[1];

  always_ff @(posedge clk) begin
    if (rst) state <= S_NORMAL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_NORMAL:   if (resolve && mispredict) state_nxt = S_REDIRECT;
      S_REDIRECT: state_nxt = S_NORMAL;
      default:    state_nxt = S_NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      redirect_pc    <= 32'h0;
      mispredict_cnt <= '0;
    end else begin
      redirect_valid <= resolve & mispredict;
      flush          <= resolve & mispredict;
      if (resolve && mispredict) begin
        redirect_pc <= taken ? ex_target : ex_pc + PC_STEP;
        if (mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_bht.sv
module tb_branch_resolve_bht;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid, ex_is_branch, ex_is_bne, ex_pred_taken, BrRes;
  logic [31:0] ex_pc, ex_target;
  logic        redirect_valid, flush;
  logic [31:0] redirect_pc;
  logic [15:0] mispredict_cnt;

  int compared = 0;
  int mismatched = 0;

  branch_resolve_bht #(.IDX_BITS(4), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_is_bne      (ex_is_bne),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .BrRes          (BrRes),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic [31:0] pc, input logic bne, input logic res,
                    input logic pred, input logic [31:0] tgt);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_is_bne = bne;
    ex_pc = pc; BrRes = res; ex_pred_taken = pred; ex_target = tgt;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_is_branch = 1'b0;
  endtask

  task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
    if_pc = pc;
    #1;
    chk(tag, {31'd0, if_pred_taken}, {31'd0, exp});
  endtask

  initial begin
    rst = 1'b1; if_pc = 32'h0; idle(); ex_is_bne = 1'b0; ex_pc = 32'h0;
    ex_target = 32'h0; ex_pred_taken = 1'b0; BrRes = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'h0);
    chk("rst_cnt", {16'd0, mispredict_cnt}, 32'd0);

    // BEQ taken, predicted not-taken -> redirect to target
    pred_at("p40_init", 32'h40, 1'b0);
    br(32'h40, 1'b0, 1'b0, 1'b0, 32'h80);
    tick(); idle();
    chk("t1_rv", {31'd0, redirect_valid}, 32'd1);
    chk("t1_flush", {31'd0, flush}, 32'd1);
    chk("t1_rpc", redirect_pc, 32'h80);
    chk("t1_cnt", {16'd0, mispredict_cnt}, 32'd1);
    tick();
    chk("t1_rv_drop", {31'd0, redirect_valid}, 32'd0);
    chk("t1_flush_drop", {31'd0, flush}, 32'd0);
    pred_at("p40_wt", 32'h40, 1'b1);

    // BNE not taken, predicted taken -> fall-through
    br(32'h40, 1'b1, 1'b0, 1'b1, 32'h80);
    tick(); idle();
    chk("t2_rpc", redirect_pc, 32'h44);
    chk("t2_cnt", {16'd0, mispredict_cnt}, 32'd2);
    tick();
    pred_at("p40_back", 32'h40, 1'b0);

    // five taken BEQs at 0x10: only the first (from WNT) mispredicts
    for (int i = 0; i < 5; i++) begin
      br(32'h10, 1'b0, 1'b0, (i != 0), 32'h200);
      tick(); idle();
      if (i == 0) tick();
    end
    chk("t3_rv_correct", {31'd0, redirect_valid}, 32'd0);
    chk("t3_cnt", {16'd0, mispredict_cnt}, 32'd3);
    pred_at("p10_sat", 32'h10, 1'b1);
    br(32'h10, 1'b0, 1'b1, 1'b1, 32'h200);
    tick(); idle();
    chk("t3_nt_rpc", redirect_pc, 32'h14);
    chk("t3_nt_cnt", {16'd0, mispredict_cnt}, 32'd4);
    tick();
    pred_at("p10_wt", 32'h10, 1'b1);

    // back-to-back mispredicts: second one sits in the REDIRECT slot
    br(32'h20, 1'b0, 1'b0, 1'b0, 32'h100);
    tick();
    br(32'h30, 1'b1, 1'b1, 1'b0, 32'h300);
    chk("t4_rv", {31'd0, redirect_valid}, 32'd1);
    chk("t4_rpc", redirect_pc, 32'h100);
    tick(); idle();
    chk("t4_no_second_rv", {31'd0, redirect_valid}, 32'd0);
    chk("t4_rpc_hold", redirect_pc, 32'h100);
    chk("t4_cnt", {16'd0, mispredict_cnt}, 32'd5);
    pred_at("p30_unchanged", 32'h30, 1'b0);
    pred_at("p20_trained", 32'h20, 1'b1);

    // fetch and EX hit index 3 in the same cycle: old value visible
    if_pc = 32'h0C;
    br(32'h0C, 1'b0, 1'b0, 1'b1, 32'h400);
    #1;
    chk("t5_old", {31'd0, if_pred_taken}, 32'd0);
    tick(); idle();
    chk("t5_new", {31'd0, if_pred_taken}, 32'd1);
    chk("t5_rv", {31'd0, redirect_valid}, 32'd0);

    // non-branch in EX: no update, no redirect
    ex_valid = 1'b1; ex_is_branch = 1'b0; ex_pc = 32'h0C; BrRes = 1'b1;
    ex_is_bne = 1'b0; ex_pred_taken = 1'b1;
    tick(); idle();
    chk("t5_nb_rv", {31'd0, redirect_valid}, 32'd0);
    pred_at("p0c_nb", 32'h0C, 1'b1);

    // not-taken mispredict at top of address space wraps to 0
    br(32'hFFFFFFFC, 1'b0, 1'b1, 1'b1, 32'hDEAD0000);
    tick(); idle();
    chk("t6_wrap_rv", {31'd0, redirect_valid}, 32'd1);
    chk("t6_wrap_rpc", redirect_pc, 32'h0);
    chk("t6_wrap_cnt", {16'd0, mispredict_cnt}, 32'd6);
    tick();

    // reset during the REDIRECT cycle
    br(32'h44, 1'b0, 1'b1, 1'b1, 32'h500);
    tick(); idle();
    chk("t7_rv_pre", {31'd0, redirect_valid}, 32'd1);
    chk("t7_rpc_pre", redirect_pc, 32'h48);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_rv", {31'd0, redirect_valid}, 32'd0);
    chk("t7_flush", {31'd0, flush}, 32'd0);
    chk("t7_cnt", {16'd0, mispredict_cnt}, 32'd0);
    chk("t7_rpc", redirect_pc, 32'h0);
    pred_at("p10_reset", 32'h10, 1'b0);
    pred_at("p20_reset", 32'h20, 1'b0);
    pred_at("p0c_reset", 32'h0C, 1'b0);
    tick();
    chk("t7_no_late_rv", {31'd0, redirect_valid}, 32'd0);
    // entry is WNT after reset: one taken step flips prediction
    br(32'h10, 1'b0, 1'b0, 1'b1, 32'h600);
    tick(); idle();
    pred_at("p10_wnt_step", 32'h10, 1'b1);
    chk("t7_no_mp", {31'd0, redirect_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/branch_resolve_bht.md
Name: branch_resolve_bht

Overview:
- Consumer end of the branch-compare path. Takes the comparator's not-equal flag BrRes for the branch in execute and resolves BEQ/BNE.
- Keeps a small table of 2-bit saturating counters. Fetch reads it for a direction prediction; execute writes it on resolution.
- On a misprediction, issues a one-cycle PC redirect plus pipeline flush.
- Sits between the IF PC mux and the EX stage, alongside the PC+imm adder.

Parameters:
- IDX_BITS, 4, BHT index width; the table has 2^IDX_BITS entries indexed by pc[IDX_BITS+1:2].
- CNT_W, 16, width of the saturating mispredict statistics counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- if_pc  in  32  PC of the instruction in fetch
- if_pred_taken  out  1  prediction for if_pc, combinational from the table
- ex_valid  in  1  EX stage holds a live instruction
- ex_is_branch  in  1  EX instruction is BEQ/BNE
- ex_is_bne  in  1  1 = BNE, 0 = BEQ
- ex_pc  in  32  PC of the EX instruction
- ex_target  in  32  PC+imm from the branch adder
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction
- BrRes  in  1  comparator result, 1 = RD1 != RD2
- redirect_valid  out  1  registered; load redirect_pc into PC
- redirect_pc  out  32  registered corrected PC
- flush  out  1  registered; squash IF/ID and ID/EX
- mispredict_cnt  out  CNT_W  saturating count of mispredictions

Behaviour:
- Reset:
  - All BHT entries = 2'b01 (weakly not-taken).
  - State = NORMAL.
  - redirect_valid = 0, flush = 0, redirect_pc = 32'h0, mispredict_cnt = 0.
  - Reset asserted mid-redirect cancels it; no redirect is emitted after reset.
- Prediction:
  - if_pred_taken = bht[if_pc[IDX_BITS+1:2]][1], combinational, zero latency.
- Resolution fires when ex_valid & ex_is_branch & state==NORMAL:
  - taken = ex_is_bne ? BrRes : ~BrRes.
  - mispredict = taken ^ ex_pred_taken.
- Table update, at the same clock edge as resolution:
  - Index = ex_pc[IDX_BITS+1:2].
  - Counter increments if taken, decrements if not taken.
  - Saturates at 2'b11 and 2'b00.
  - Correctly predicted branches are also updated.
- Read/write collision: if fetch reads the entry being updated in the same cycle, the read returns the pre-update value (no bypass).
- FSM, two states:
  - NORMAL: on resolution with mispredict, go to REDIRECT and register:
    - redirect_valid = 1, flush = 1
    - redirect_pc = taken ? ex_target : ex_pc + 32'd4 (modulo 2^32, wrap permitted)
    - mispredict_cnt += 1, saturating at all-ones
  - REDIRECT: lasts exactly one cycle, with redirect_valid and flush high. Any EX input this cycle is a squashed wrong-path instruction and is ignored: no table update, no count, no new redirect. Next state is NORMAL; redirect_valid and flush return to 0.
- Redirect latency: exactly 1 cycle after the resolving edge. Outputs are held for 1 cycle only.
- Non-branch or ex_valid=0: no update, no redirect.
- Back-to-back mispredicting branches in consecutive cycles: the second is in the REDIRECT slot and is dropped by design, since the pipeline flushes it.
- Targets are not checked for alignment here.

Decomposition:
- Shared package holds:
  - BHT counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11
  - FSM state constants S_NORMAL, S_REDIRECT
  - PC_STEP = 32'd4
- One natural sub-module: bht_2bit. It owns the counter array, the combinational read port, the saturating write port and the reset init. The top keeps the FSM, the taken/mispredict logic, the redirect registers and the statistics counter.

Test Plan:
- Reset, then if_pc=0x00000040 → if_pred_taken=0. Resolve BEQ at ex_pc=0x40 with BrRes=0, ex_pred_taken=0, ex_target=0x80 → next cycle redirect_valid=1, flush=1, redirect_pc=0x80, mispredict_cnt=1; the following cycle redirect_valid=0.
- BNE at ex_pc=0x40, BrRes=0, ex_pred_taken=1 → redirect_pc=0x44. Entry 0x40 steps toward not-taken.
- Five consecutive taken BEQs at 0x10 (BrRes=0), each with prediction matching the entry → counter saturates at 2'b11, if_pred_taken=1, one mispredict at most. One not-taken resolve → entry = 2'b10, prediction still 1.
- Mispredicting branch, then next cycle ex_valid=1 with another mispredicting branch → only one redirect, mispredict_cnt +1, second branch's entry unchanged.
- Same-cycle fetch read and EX update of index 3 → if_pred_taken shows the old value; the new value is visible the next cycle.
- rst asserted in the REDIRECT cycle → next cycle redirect_valid=0, flush=0, mispredict_cnt=0, all entries read 2'b01. Separately, ex_pc=0xFFFFFFFC, not-taken mispredict → redirect_pc=0x00000000.
